// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and parity modes.
package uart_pkg;

    // Transmit framer states (3-bit, legacy-compatible encoding)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity mode selector values
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Line level for the parity bit given the XOR of all data bits
    function automatic logic parity_level(input logic acc, input int mode);
        return (mode == PARITY_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2
// stop bits. Bit periods are ended by the external baud tick; count_en keeps
// the baud generator running while a frame is on the line.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 baud_tick,
    output logic                 count_en,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             HAS_PAR   = (PARITY_MODE != PARITY_NONE);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 count_en_q, count_en_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;

    // Next-state logic plus output decode from the next state, so every
    // output can be registered and still change on the tick-sampling edge
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d    = tx_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    parity_d   = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    parity_d  = parity_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
        count_en_d = (state_d != IDLE);
        tx_busy_d  = (state_d != IDLE);

        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_level(parity_d, PARITY_MODE);
            default: tx_out_d = 1'b1;
        endcase
    end

    // State and registered outputs; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            count_en_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            count_en_q <= count_en_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign count_en = count_en_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer. Four instances cover the parameter
// sets: 0 = default, 1 = even parity, 2 = odd parity, 3 = two stop bits.
// Each has a baud generator model that ticks every 21 enabled cycles.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data  [4];
    logic       valid [4];
    logic       ready [4];
    logic       cen   [4];
    logic       txo   [4];
    logic       busy  [4];
    logic       done  [4];
    logic       tick  [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        int bcnt = 0;

        // Baud generator model: counts while enabled, tick on count 20
        always @(posedge clk) begin
            if (!cen[gi])        bcnt <= 0;
            else if (bcnt == 20) bcnt <= 0;
            else                 bcnt <= bcnt + 1;
        end
        assign tick[gi] = cen[gi] && (bcnt == 20);

        uart_tx_framer #(
            .DATA_BITS  (8),
            .PARITY_MODE(gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
            .STOP_BITS  (gi == 3 ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (data[gi]),
            .tx_valid (valid[gi]),
            .tx_ready (ready[gi]),
            .baud_tick(tick[gi]),
            .count_en (cen[gi]),
            .tx_out   (txo[gi]),
            .tx_busy  (busy[gi]),
            .tx_done  (done[gi])
        );
    end

    // Sends one word on instance k and records the line level at each tick.
    // Cycle 0 is the first cycle of the start bit.
    task automatic send_frame(input int k, input logic [7:0] d,
                              output logic [31:0] bits, output int nt,
                              output int done_at, output int done_cnt,
                              output int bad, output logic done_ok);
        bits = '0; nt = 0; done_at = -1; done_cnt = 0; bad = 0; done_ok = 1'b0;
        @(negedge clk);
        data[k]  = d;
        valid[k] = 1'b1;
        @(posedge clk);
        #1 valid[k] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (tick[k]) begin
                if (nt < 32) bits[nt] = txo[k];
                nt++;
            end
            if (done[k]) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    done_ok = ready[k] && !cen[k];
                end
            end else if (done_at < 0 && (ready[k] || !busy[k] || !cen[k])) begin
                bad++;
            end
            if (done_at >= 0 && c >= done_at + 5) break;
        end
        $display("frame inst=%0d data=%02h ticks=%0d bits=%h done_at=%0d", k, d, nt, bits, done_at);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({txo[k], ready[k], cen[k], busy[k], done[k]} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_hold inst=%0d got=%b want=11000", k,
                         {txo[k], ready[k], cen[k], busy[k], done[k]});
            end
        end
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if ({txo[k], ready[k], cen[k], busy[k], done[k]} !== 5'b11000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle bad_cycles=%0d want=0", bad);
        end
        $display("reset released, idle watched 50 cycles");
    endtask

    task automatic test_basic();
        logic [31:0] bits; int nt, da, dc, bad; logic ok;
        send_frame(0, 8'hA5, bits, nt, da, dc, bad, ok);
        checks++; if (bits !== 32'h34A) begin errors++; $display("FAIL basic_bits got=%h want=34a", bits); end
        checks++; if (nt !== 10)        begin errors++; $display("FAIL basic_ticks got=%0d want=10", nt); end
        checks++; if (da !== 210)       begin errors++; $display("FAIL basic_done_at got=%0d want=210", da); end
        checks++; if (dc !== 1)         begin errors++; $display("FAIL basic_done_cnt got=%0d want=1", dc); end
        checks++; if (bad !== 0)        begin errors++; $display("FAIL basic_ctrl bad=%0d want=0", bad); end
        checks++; if (ok !== 1'b1)      begin errors++; $display("FAIL basic_done_cycle got=%b want=1", ok); end
    endtask

    task automatic test_parity();
        logic [31:0] bits; int nt, da, dc, bad; logic ok;
        send_frame(1, 8'hA5, bits, nt, da, dc, bad, ok);
        checks++; if (bits !== 32'h54A) begin errors++; $display("FAIL even_bits got=%h want=54a", bits); end
        checks++; if (bits[9] !== 1'b0) begin errors++; $display("FAIL even_parity got=%b want=0", bits[9]); end
        checks++; if (nt !== 11)        begin errors++; $display("FAIL even_ticks got=%0d want=11", nt); end
        checks++; if (da !== 231 || dc !== 1 || bad !== 0 || ok !== 1'b1) begin
            errors++; $display("FAIL even_done got=%0d/%0d/%0d/%b want=231/1/0/1", da, dc, bad, ok);
        end
        send_frame(2, 8'h00, bits, nt, da, dc, bad, ok);
        checks++; if (bits !== 32'h600) begin errors++; $display("FAIL odd_bits got=%h want=600", bits); end
        checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL odd_parity got=%b want=1", bits[9]); end
        checks++; if (nt !== 11)        begin errors++; $display("FAIL odd_ticks got=%0d want=11", nt); end
        checks++; if (da !== 231 || dc !== 1 || bad !== 0 || ok !== 1'b1) begin
            errors++; $display("FAIL odd_done got=%0d/%0d/%0d/%b want=231/1/0/1", da, dc, bad, ok);
        end
    endtask

    task automatic test_two_stop();
        logic [31:0] bits; int nt, da, dc, bad; logic ok;
        send_frame(3, 8'hFF, bits, nt, da, dc, bad, ok);
        checks++; if (bits !== 32'h7FE)     begin errors++; $display("FAIL stop2_bits got=%h want=7fe", bits); end
        checks++; if (bits[10:9] !== 2'b11) begin errors++; $display("FAIL stop2_high got=%b want=11", bits[10:9]); end
        checks++; if (nt !== 11)            begin errors++; $display("FAIL stop2_ticks got=%0d want=11", nt); end
        checks++; if (da !== 231)           begin errors++; $display("FAIL stop2_done_at got=%0d want=231", da); end
        checks++; if (dc !== 1 || bad !== 0 || ok !== 1'b1) begin
            errors++; $display("FAIL stop2_done got=%0d/%0d/%b want=1/0/1", dc, bad, ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits = '0;
        int nt = 0, dc = 0, d1 = -1, d2 = -1, bad_ready = 0;
        logic gap_ok = 1'b0;
        @(negedge clk);
        data[0]  = 8'h3C;
        valid[0] = 1'b1;
        @(posedge clk);
        #1 data[0] = 8'hC3;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            if (tick[0]) begin
                if (nt < 32) bits[nt] = txo[0];
                nt++;
            end
            if (done[0]) begin
                dc++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end else if (dc < 2 && ready[0]) begin
                bad_ready++;
            end
            if (d1 >= 0 && c == d1 + 1) begin
                gap_ok = (txo[0] === 1'b0) && (busy[0] === 1'b1) && (ready[0] === 1'b0);
                valid[0] = 1'b0;
            end
            if (d2 >= 0 && c >= d2 + 5) break;
        end
        valid[0] = 1'b0;
        $display("back_to_back ticks=%0d bits=%h done1=%0d done2=%0d", nt, bits, d1, d2);
        checks++; if (bits !== 32'hE1A78) begin errors++; $display("FAIL b2b_bits got=%h want=e1a78", bits); end
        checks++; if (nt !== 20)          begin errors++; $display("FAIL b2b_ticks got=%0d want=20", nt); end
        checks++; if (d1 !== 210 || d2 !== 421) begin
            errors++; $display("FAIL b2b_done_at got=%0d/%0d want=210/421", d1, d2);
        end
        checks++; if (dc !== 2)           begin errors++; $display("FAIL b2b_done_cnt got=%0d want=2", dc); end
        checks++; if (gap_ok !== 1'b1)    begin errors++; $display("FAIL b2b_gap got=%b want=1", gap_ok); end
        checks++; if (bad_ready !== 0)    begin errors++; $display("FAIL b2b_ready_midframe got=%0d want=0", bad_ready); end
    endtask

    task automatic test_reset_midframe();
        int nt = 0, dc = 0;
        logic line_before = 1'bx;
        @(negedge clk);
        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        for (int c = 0; c < 200 && nt < 4; c++) begin
            @(negedge clk);
            if (tick[0]) nt++;
        end
        @(negedge clk);
        line_before = txo[0];
        #2 rst_n = 1'b0;
        #1;
        checks++; if (line_before !== 1'b0) begin errors++; $display("FAIL midrst_bit3 got=%b want=0", line_before); end
        checks++;
        if ({txo[0], ready[0], cen[0], busy[0], done[0]} !== 5'b11000) begin
            errors++;
            $display("FAIL midrst_async got=%b want=11000", {txo[0], ready[0], cen[0], busy[0], done[0]});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done[0] || !txo[0]) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL midrst_after got=%0d want=0", dc); end
        $display("reset mid-frame during data bit 3");
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            data[k]  = 8'h00;
            valid[k] = 1'b0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
